// File: rtl/drop_controller.sv
// drop_controller: Connect-4 game-side writer. Moves the column cursor and
// animates a falling token row by row. It then issues a single one-cycle write
// into the win checker and samples winflag to decide win, draw or next turn.
module drop_controller #(
    parameter int FALL_DIV  = 2500000,
    parameter int ADDR_BASE = 11,
    parameter int ADDR_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_drop,
    input  logic       new_game,
    input  logic       winflag,
    output logic [2:0] colval,
    output logic [4:0] waddr,
    output logic       Player,
    output logic [2:0] cursor_col,
    output logic [2:0] anim_row,
    output logic       anim_active,
    output logic       game_over,
    output logic       winner,
    output logic       board_full
);

    localparam int CNT_W = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FALL_DIV - 1);

    typedef enum logic [2:0] {
        S_SELECT    = 3'd0,
        S_FALLING   = 3'd1,
        S_WRITE     = 3'd2,
        S_CHECK     = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t           r_state;
    logic [2:0]       r_heights [0:6];
    logic [5:0]       r_moves;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_target;
    logic [2:0]       r_colval;
    logic [4:0]       r_waddr;
    logic             r_player;
    logic [2:0]       r_cursor;
    logic [2:0]       r_anim_row;
    logic             r_anim_active;
    logic             r_game_over;
    logic             r_winner;
    logic             r_board_full;

    logic [2:0]       w_cur_height;
    logic             w_col_full;
    logic [2:0]       w_target;
    logic [4:0]       w_waddr;
    logic [2:0]       w_cursor_nxt;

    assign w_cur_height = r_heights[r_cursor];
    assign w_col_full   = (w_cur_height == 3'd6);
    // Row 0 is the top, so the landing row counts down from 5 as the column fills.
    assign w_target     = 3'd5 - w_cur_height;
    assign w_waddr      = 5'(ADDR_BASE + ADDR_STEP * int'(r_target));

    // Saturating cursor step; simultaneous left+right cancels out.
    always_comb begin
        w_cursor_nxt = r_cursor;
        if (btn_left && !btn_right) begin
            if (r_cursor != 3'd0) begin
                w_cursor_nxt = r_cursor - 3'd1;
            end else begin
                w_cursor_nxt = r_cursor;
            end
        end else if (btn_right && !btn_left) begin
            if (r_cursor != 3'd6) begin
                w_cursor_nxt = r_cursor + 3'd1;
            end else begin
                w_cursor_nxt = r_cursor;
            end
        end else begin
            w_cursor_nxt = r_cursor;
        end
    end

    // Game state machine; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_SELECT;
            for (int i = 0; i < 7; i++) begin
                r_heights[i] <= 3'd0;
            end
            r_moves       <= 6'd0;
            r_cnt         <= '0;
            r_target      <= 3'd0;
            r_colval      <= 3'd7;
            r_waddr       <= 5'd0;
            r_player      <= 1'b1;
            r_cursor      <= 3'd3;
            r_anim_row    <= 3'd0;
            r_anim_active <= 1'b0;
            r_game_over   <= 1'b0;
            r_winner      <= 1'b0;
            r_board_full  <= 1'b0;
        end else begin
            case (r_state)
                S_SELECT: begin
                    // Drop wins over cursor movement and freezes the cursor.
                    if (btn_drop) begin
                        if (!w_col_full) begin
                            r_target      <= w_target;
                            r_anim_row    <= 3'd0;
                            r_cnt         <= '0;
                            r_anim_active <= 1'b1;
                            r_state       <= S_FALLING;
                        end
                    end else begin
                        r_cursor <= w_cursor_nxt;
                    end
                end
                S_FALLING: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_anim_row == r_target) begin
                            // Present the write for exactly the WRITE cycle.
                            r_colval <= r_cursor;
                            r_waddr  <= w_waddr;
                            r_state  <= S_WRITE;
                        end else begin
                            r_anim_row <= r_anim_row + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    r_colval            <= 3'd7;
                    r_heights[r_cursor] <= r_heights[r_cursor] + 3'd1;
                    r_moves             <= r_moves + 6'd1;
                    r_anim_active       <= 1'b0;
                    r_state             <= S_CHECK;
                end
                S_CHECK: begin
                    // The checker board took the write on the previous edge.
                    if (winflag) begin
                        r_game_over <= 1'b1;
                        r_winner    <= r_player;
                        r_state     <= S_GAME_OVER;
                    end else if (r_moves == 6'd42) begin
                        r_game_over  <= 1'b1;
                        r_board_full <= 1'b1;
                        r_state      <= S_GAME_OVER;
                    end else begin
                        r_player <= ~r_player;
                        r_state  <= S_SELECT;
                    end
                end
                S_GAME_OVER: begin
                    if (new_game) begin
                        for (int i = 0; i < 7; i++) begin
                            r_heights[i] <= 3'd0;
                        end
                        r_moves      <= 6'd0;
                        r_player     <= 1'b1;
                        r_cursor     <= 3'd3;
                        r_anim_row   <= 3'd0;
                        r_game_over  <= 1'b0;
                        r_winner     <= 1'b0;
                        r_board_full <= 1'b0;
                        r_state      <= S_SELECT;
                    end
                end
                default: begin
                    r_colval      <= 3'd7;
                    r_anim_active <= 1'b0;
                    r_state       <= S_SELECT;
                end
            endcase
        end
    end

    assign colval      = r_colval;
    assign waddr       = r_waddr;
    assign Player      = r_player;
    assign cursor_col  = r_cursor;
    assign anim_row    = r_anim_row;
    assign anim_active = r_anim_active;
    assign game_over   = r_game_over;
    assign winner      = r_winner;
    assign board_full  = r_board_full;

endmodule

// File: tb/tb_drop_controller.sv
// Bench for drop_controller: randomized cursor/drop stimulus against a
// board-level game model, a behavioural win checker fed by the DUT writes,
// and a write scoreboard checked by an independent monitor.
module tb_drop_controller;

    localparam int FALL_DIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_drop = 1'b0;
    logic       new_game = 1'b0, clr_board = 1'b0;
    logic       winflag;
    logic [2:0] colval, cursor_col, anim_row;
    logic [4:0] waddr;
    logic       Player, anim_active, game_over, winner, board_full;

    drop_controller #(.FALL_DIV(FALL_DIV), .ADDR_BASE(11), .ADDR_STEP(4)) dut (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
        .btn_drop(btn_drop), .new_game(new_game), .winflag(winflag),
        .colval(colval), .waddr(waddr), .Player(Player), .cursor_col(cursor_col),
        .anim_row(anim_row), .anim_active(anim_active), .game_over(game_over),
        .winner(winner), .board_full(board_full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { int col; int addr; int pl; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    // Board cells indexed col*6 + height (height 0 = bottom).
    function automatic bit check_win(input logic [41:0] occ, input logic [41:0] own);
        bit found = 1'b0;
        for (int pl = 0; pl < 2; pl++)
            for (int c = 0; c < 7; c++)
                for (int h = 0; h < 6; h++)
                    for (int d = 0; d < 4; d++) begin
                        int dc, dh, n;
                        dc = (d == 1) ? 0 : 1;
                        dh = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
                        n = 0;
                        for (int k = 0; k < 4; k++) begin
                            int cc, hh;
                            cc = c + k * dc;
                            hh = h + k * dh;
                            if (cc >= 0 && cc < 7 && hh >= 0 && hh < 6)
                                if (occ[cc*6+hh] && (own[cc*6+hh] == pl[0])) n++;
                        end
                        if (n == 4) found = 1'b1;
                    end
        return found;
    endfunction

    // Behavioural win checker: records each DUT write on the clock edge.
    logic [41:0] chk_occ, chk_own;
    int chk_idx;
    always_comb chk_idx = int'(colval) * 6 + 5 - (int'(waddr) - 11) / 4;
    always @(posedge clk or posedge rst) begin
        if (rst || clr_board) begin
            chk_occ <= '0;
            chk_own <= '0;
        end else if (colval != 3'd7 && chk_idx >= 0 && chk_idx < 42) begin
            chk_occ[chk_idx] <= 1'b1;
            chk_own[chk_idx] <= Player;
        end
    end
    assign winflag = check_win(chk_occ, chk_own);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with colval != 7 must match the next expected write.
    always @(negedge clk) begin
        if (!rst && colval != 3'd7) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: colval=%0d waddr=%0d expected none", colval, waddr);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_col", int'(colval), mon_e.col);
                check("write_addr", int'(waddr), mon_e.addr);
                check("write_player", int'(Player), mon_e.pl);
            end
        end
    end

    // Reference game model
    int          m_h[7];
    int          m_moves, m_cursor;
    bit          m_player, m_over, m_winner, m_full;
    logic [41:0] m_occ, m_own;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 7; c++) m_h[c] = 0;
        m_moves = 0; m_cursor = 3; m_player = 1'b1;
        m_over = 1'b0; m_winner = 1'b0; m_full = 1'b0;
        m_occ = '0; m_own = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_Player"}, int'(Player), int'(m_player));
        check({tag, "_cursor"}, int'(cursor_col), m_cursor);
        check({tag, "_game_over"}, int'(game_over), int'(m_over));
        check({tag, "_winner"}, int'(winner), int'(m_winner));
        check({tag, "_board_full"}, int'(board_full), int'(m_full));
        check({tag, "_anim_active"}, int'(anim_active), 0);
        check({tag, "_colval"}, int'(colval), 7);
    endtask

    // Asynchronous reset: outputs must take reset values without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        exp_q.delete();
        check("rst_waddr", int'(waddr), 0);
        check("rst_anim_row", int'(anim_row), 0);
        check_outputs("rst");
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic press(input bit l, input bit r);
        btn_left = l; btn_right = r;
        tick();
        btn_left = 1'b0; btn_right = 1'b0;
        if (!m_over) begin
            if (l && !r && m_cursor > 0) m_cursor--;
            if (r && !l && m_cursor < 6) m_cursor++;
        end
        check("cursor_move", int'(cursor_col), m_cursor);
    endtask

    task automatic goto_col(input int col);
        int guard = 0;
        while (m_cursor != col && guard < 10) begin
            press(col < m_cursor, col > m_cursor);
            guard++;
        end
    endtask

    task automatic do_drop(input bit also_left);
        int c, row, n;
        c = m_cursor;
        btn_drop = 1'b1; btn_left = also_left;
        tick();
        btn_drop = 1'b0; btn_left = 1'b0;
        if (m_over || m_h[c] == 6) begin
            check("ignored_drop_active", int'(anim_active), 0);
            tick();
            check_outputs("ignored_drop");
            return;
        end
        row = 5 - m_h[c];
        exp_q.push_back('{col: c, addr: 11 + 4 * row, pl: int'(m_player)});
        n = 0;
        while (anim_active === 1'b1 && colval === 3'd7 && n < 200) begin
            check("anim_row", int'(anim_row), n / FALL_DIV);
            btn_left = (n == 1);
            btn_right = (n == 3);
            n++;
            tick();
        end
        btn_left = 1'b0; btn_right = 1'b0;
        check("fall_cycles", n, (row + 1) * FALL_DIV);
        tick();
        check("after_write_colval", int'(colval), 7);
        tick();
        m_occ[c*6 + m_h[c]] = 1'b1;
        m_own[c*6 + m_h[c]] = m_player;
        m_h[c]++;
        m_moves++;
        if (check_win(m_occ, m_own)) begin
            m_over = 1'b1; m_winner = m_player;
        end else if (m_moves == 42) begin
            m_over = 1'b1; m_full = 1'b1;
        end else begin
            m_player = ~m_player;
        end
        check_outputs("after_drop");
    endtask

    initial begin
        int seq[$];
        int pa[3];
        int pb[3];
        int guard;
        pa = '{1, 4, 5};
        pb = '{2, 3, 6};
        tick();
        do_reset();

        // Test 1/2: col 3 six times, 7th ignored; new_game ignored outside GAME_OVER
        for (int i = 0; i < 7; i++) do_drop(1'b0);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        check_outputs("newgame_ignored");

        // Test 3: cursor saturation, cancel, drop priority, random moves
        do_reset();
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
        check("cursor_left_sat", int'(cursor_col), 0);
        for (int i = 0; i < 9; i++) press(1'b0, 1'b1);
        check("cursor_right_sat", int'(cursor_col), 6);
        press(1'b1, 1'b1);
        do_drop(1'b1);
        for (int i = 0; i < 6; i++) begin
            goto_col($urandom_range(0, 6));
            do_drop($urandom_range(0, 1) == 1);
        end

        // Test 4: vertical win for P1 in col 0, then game-over lockout and new_game
        do_reset();
        for (int i = 0; i < 7; i++) begin
            goto_col(i % 2);
            do_drop(1'b0);
        end
        check("win_game_over", int'(game_over), 1);
        check("win_winner", int'(winner), 1);
        press(1'b0, 1'b1);
        do_drop(1'b0);
        new_game = 1'b1; clr_board = 1'b1;
        tick();
        new_game = 1'b0; clr_board = 1'b0;
        model_reset();
        check("newgame_Player", int'(Player), 1);
        check("newgame_cursor", int'(cursor_col), 3);
        check("newgame_game_over", int'(game_over), 0);
        check("newgame_board_full", int'(board_full), 0);

        // Test 5: 42-move draw
        do_reset();
        for (int i = 0; i < 6; i++) seq.push_back(0);
        for (int p = 0; p < 3; p++) begin
            seq.push_back(pa[p]);
            for (int i = 0; i < 6; i++) seq.push_back(pb[p]);
            for (int i = 0; i < 5; i++) seq.push_back(pa[p]);
        end
        foreach (seq[i]) begin
            goto_col(seq[i]);
            do_drop(1'b0);
        end
        check("draw_board_full", int'(board_full), 1);
        check("draw_game_over", int'(game_over), 1);
        check("draw_winner", int'(winner), 0);

        // Test 6: reset mid-fall at anim_row 2 aborts the write
        do_reset();
        goto_col($urandom_range(0, 6));
        btn_drop = 1'b1;
        tick();
        btn_drop = 1'b0;
        guard = 0;
        while (anim_row !== 3'd2 && guard < 50) begin
            tick();
            guard++;
        end
        check("reach_row2", int'(anim_row), 2);
        do_reset();
        for (int i = 0; i < 30; i++) tick();
        check("abort_anim_active", int'(anim_active), 0);
        check("abort_Player", int'(Player), 1);

        tick();
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
